decoded_instr_queue: RTL and testbench
======================================

Name: decoded_instr_queue

Overview:
- Small FIFO of decoded instructions (scoreboard_entry_t) between the decoder and issue_stage.
- Decouples decode stalls from issue back-pressure.
- Enforces a single-unresolved-branch rule: once a control-flow instruction is handed to issue, the next control-flow instruction is held until the branch resolves.
- Upstream handshake is valid/ready; downstream matches issue_stage's decoded_instr_valid_i / decoded_instr_ack_o pair.

Parameters:
- DEPTH, 4: number of entries; power of two, 2..16.
- PTR_W, $clog2(DEPTH): pointer width (derived, not overridable).

Ports:
- clk_i  input  1  clock
- rst_ni  input  1  asynchronous reset, active low
- flush_i  input  1  drop all queued entries and clear branch state
- instr_i  input  $bits(scoreboard_entry_t)  decoded instruction from decoder
- instr_valid_i  input  1  decoder has an instruction
- is_ctrl_flow_i  input  1  instr_i is a branch/jump
- instr_ready_o  output  1  queue accepts instr_i this cycle
- decoded_instr_o  output  $bits(scoreboard_entry_t)  head entry to issue_stage
- decoded_instr_valid_o  output  1  head entry offered to issue
- is_ctrl_flow_o  output  1  head entry is control flow
- decoded_instr_ack_i  input  1  issue_stage consumed the head entry
- resolve_branch_i  input  1  execute resolved the outstanding branch
- count_o  output  PTR_W+1  number of queued entries
- unresolved_branch_o  output  1  a control-flow instruction is in flight

Behaviour:
- Clocking and reset: one clock; reset is asynchronous and active-low (clk_i, rst_ni).
- Reset values:
  - Pointers, count_o and the unresolved flag are 0.
  - decoded_instr_valid_o=0, is_ctrl_flow_o=0, unresolved_branch_o=0.
  - instr_ready_o=1.
  - Entry storage need not be reset; decoded_instr_o is don't-care while valid is 0.
- Storage: DEPTH entries, each {scoreboard_entry_t, ctrl_flow bit}. Read pointer, write pointer and a PTR_W+1 counter; pointers wrap modulo DEPTH.
- Push: fires when instr_valid_i && instr_ready_o.
  - instr_ready_o = (count_o != DEPTH) && !flush_i.
  - When full, ready is low even if a pop occurs in the same cycle. This is a deliberate no-bypass decision.
- Head visibility: head = entry at read pointer, driven combinationally from storage.
  - No fall-through: an entry pushed in cycle N is first offered in cycle N+1.
  - Minimum latency is 1 cycle.
- Branch gate: blocked = unresolved_branch_q && head.ctrl_flow.
  - decoded_instr_valid_o = (count_o != 0) && !blocked && !flush_i.
  - is_ctrl_flow_o = head.ctrl_flow, qualified by count_o != 0.
- Pop: fires when decoded_instr_valid_o && decoded_instr_ack_i. An ack with valid low is ignored.
- Count update: push without pop gives +1; pop without push gives -1; push and pop together leave count unchanged (only possible when not full).
- Unresolved flag, next-state priority:
  1. flush_i: clear to 0.
  2. Pop of a ctrl_flow entry: set to 1. This wins over a same-cycle resolve_branch_i, because the resolve belongs to the previous branch.
  3. resolve_branch_i: clear to 0.
  4. Otherwise: hold.
- unresolved_branch_o reflects the registered flag.
- Gate scope: non-control-flow entries behind an in-flight branch keep flowing. Only a second control-flow head is held.
- Flush, single cycle:
  - Pointers and count go to 0 at the next edge.
  - Any same-cycle push is dropped (ready is low) and no pop occurs (valid is low).
  - From the next cycle the queue is empty and ready.
- Reset mid-operation: asynchronous return to the reset values; contents are discarded.
- Empty: valid=0; ack ignored. Full: ready=0; the decoder holds instr_i stable.

Test Plan:
- Fill/drain: DEPTH=4; push A,B,C,D back-to-back with ack=0 → count_o=4, ready=0 in cycle 5. Then ack every cycle → A,B,C,D emerge in order, count returns to 0, valid=0.
- Latency/throughput: push 1/cycle with ack held 1 → first valid one cycle after first push; steady state of 1 pop/cycle; count_o stays at 1.
- Branch gate: queue BR1(ctrl), ADD, BR2(ctrl); ack=1, no resolve:
  - BR1 pops and unresolved_branch_o=1.
  - ADD pops.
  - BR2 is head with valid=0 for 5 cycles.
  - resolve_branch_i pulse → valid=1 next cycle.
- Resolve/pop collision: unresolved=1, head ctrl entry blocked. Then place a new ctrl entry at head with the flag clear, and pop it in the same cycle as resolve_branch_i → flag stays 1.
- Flush: 3 entries queued and flag=1; assert flush_i with instr_valid_i=1 → that cycle ready=0 and valid=0; next cycle count_o=0 and flag=0; the pushed instruction is lost.
- Async reset: rst_ni low mid-stream with 2 entries → outputs go to reset values immediately without waiting for a clock edge. After release, push X → X offered with count_o=1.

Source files
------------

// File: rtl/decoded_instr_queue.sv
// ---------------------------------------------------------------------------
// decoded_instr_queue
//
// Small FIFO of decoded instructions sitting between the decoder and the
// issue stage. Decode stalls are decoupled from issue back-pressure, and at
// most one control-flow instruction may be unresolved downstream at a time:
// once a branch/jump has been handed to issue, a later control-flow entry is
// held at the head until execute reports the branch resolved.
//
// Parameters
//   DEPTH    number of entries (power of two, 2..16)
//   ENTRY_W  width of one decoded instruction (scoreboard entry)
//   PTR_W    pointer width, derived from DEPTH
//
// Ports
//   clk_i                 clock
//   rst_ni                asynchronous reset, active low
//   flush_i               drop every queued entry and clear branch state
//   instr_i               decoded instruction from the decoder
//   instr_valid_i         decoder offers instr_i
//   is_ctrl_flow_i        instr_i is a branch/jump
//   instr_ready_o         queue accepts instr_i this cycle
//   decoded_instr_o       head entry towards issue
//   decoded_instr_valid_o head entry is offered to issue
//   is_ctrl_flow_o        head entry is control flow
//   decoded_instr_ack_i   issue consumed the head entry
//   resolve_branch_i      execute resolved the outstanding branch
//   count_o               number of queued entries
//   unresolved_branch_o   a control-flow instruction is in flight
// ---------------------------------------------------------------------------
module decoded_instr_queue #(
    parameter int unsigned DEPTH   = 4,
    parameter int unsigned ENTRY_W = 64,
    localparam int unsigned PTR_W  = $clog2(DEPTH)
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               flush_i,
    input  logic [ENTRY_W-1:0] instr_i,
    input  logic               instr_valid_i,
    input  logic               is_ctrl_flow_i,
    output logic               instr_ready_o,
    output logic [ENTRY_W-1:0] decoded_instr_o,
    output logic               decoded_instr_valid_o,
    output logic               is_ctrl_flow_o,
    input  logic               decoded_instr_ack_i,
    input  logic               resolve_branch_i,
    output logic [PTR_W:0]     count_o,
    output logic               unresolved_branch_o
);

    localparam logic [PTR_W:0]   DEPTH_C   = (PTR_W + 1)'(DEPTH);
    localparam logic [PTR_W:0]   CNT_ZERO  = {(PTR_W + 1){1'b0}};
    localparam logic [PTR_W:0]   CNT_ONE   = (PTR_W + 1)'(1);
    localparam logic [PTR_W-1:0] PTR_ZERO  = {PTR_W{1'b0}};
    localparam logic [PTR_W-1:0] PTR_ONE   = PTR_W'(1);

    // Entry storage; intentionally left without reset, only count_q says
    // which slots hold live data.
    logic [ENTRY_W-1:0] mem_q [DEPTH];
    logic [DEPTH-1:0]   ctrl_q;

    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W:0]   count_q,  count_d;
    logic             unresolved_q, unresolved_d;

    logic full_s;
    logic empty_s;
    logic head_ctrl_s;
    logic blocked_s;
    logic ready_s;
    logic valid_s;
    logic push_s;
    logic pop_s;

    // Handshake qualification and branch gate, all derived from current state.
    always_comb begin
        full_s      = (count_q == DEPTH_C);
        empty_s     = (count_q == CNT_ZERO);
        head_ctrl_s = ctrl_q[rd_ptr_q];
        // Only a second control-flow head is held; plain entries keep flowing.
        blocked_s   = unresolved_q && head_ctrl_s;
        // No bypass when full: a same-cycle pop does not open a slot.
        ready_s     = !full_s && !flush_i;
        valid_s     = !empty_s && !blocked_s && !flush_i;
        push_s      = instr_valid_i && ready_s;
        pop_s       = valid_s && decoded_instr_ack_i;
    end

    // Next-state computation for pointers, occupancy and the branch flag.
    always_comb begin
        rd_ptr_d     = rd_ptr_q;
        wr_ptr_d     = wr_ptr_q;
        count_d      = count_q;
        unresolved_d = unresolved_q;
        if (flush_i) begin
            rd_ptr_d     = PTR_ZERO;
            wr_ptr_d     = PTR_ZERO;
            count_d      = CNT_ZERO;
            unresolved_d = 1'b0;
        end else begin
            // Pointers wrap naturally because DEPTH is a power of two.
            if (push_s) begin
                wr_ptr_d = wr_ptr_q + PTR_ONE;
            end else begin
                wr_ptr_d = wr_ptr_q;
            end
            if (pop_s) begin
                rd_ptr_d = rd_ptr_q + PTR_ONE;
            end else begin
                rd_ptr_d = rd_ptr_q;
            end
            case ({push_s, pop_s})
                2'b10:   count_d = count_q + CNT_ONE;
                2'b01:   count_d = count_q - CNT_ONE;
                default: count_d = count_q;
            endcase
            // Handing out a new branch outranks a resolve in the same cycle:
            // that resolve belongs to the previous branch.
            if (pop_s && head_ctrl_s) begin
                unresolved_d = 1'b1;
            end else if (resolve_branch_i) begin
                unresolved_d = 1'b0;
            end else begin
                unresolved_d = unresolved_q;
            end
        end
    end

    // Control state registers with asynchronous reset.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rd_ptr_q     <= PTR_ZERO;
            wr_ptr_q     <= PTR_ZERO;
            count_q      <= CNT_ZERO;
            unresolved_q <= 1'b0;
        end else begin
            rd_ptr_q     <= rd_ptr_d;
            wr_ptr_q     <= wr_ptr_d;
            count_q      <= count_d;
            unresolved_q <= unresolved_d;
        end
    end

    // Entry write port; an entry becomes visible at the head one cycle later.
    always_ff @(posedge clk_i) begin
        if (push_s) begin
            mem_q[wr_ptr_q]  <= instr_i;
            ctrl_q[wr_ptr_q] <= is_ctrl_flow_i;
        end
    end

    // Output drive.
    always_comb begin
        instr_ready_o         = ready_s;
        decoded_instr_o       = mem_q[rd_ptr_q];
        decoded_instr_valid_o = valid_s;
        is_ctrl_flow_o        = !empty_s && head_ctrl_s;
        count_o               = count_q;
        unresolved_branch_o   = unresolved_q;
    end

endmodule

// File: tb/tb_decoded_instr_queue.sv
// ---------------------------------------------------------------------------
// tb_decoded_instr_queue
//
// Scoreboard bench for decoded_instr_queue. A reference model (a queue of
// control-flow bits plus the unresolved flag) predicts the handshake outputs
// every cycle; entries it predicts as accepted go into a scoreboard queue
// that an independent monitor pops whenever the DUT completes a hand-off to
// issue. Directed scenarios are followed by a randomized phase.
// ---------------------------------------------------------------------------
module tb_decoded_instr_queue;

    localparam int DEPTH = 4;
    localparam int W     = 32;
    localparam int PW    = $clog2(DEPTH);

    typedef struct {
        logic [W-1:0] data;
        logic         ctrl;
    } ent_t;

    logic         clk = 1'b0;
    logic         rst_ni = 1'b0;
    logic         flush_i = 1'b0;
    logic [W-1:0] instr_i = '0;
    logic         instr_valid_i = 1'b0;
    logic         is_ctrl_flow_i = 1'b0;
    logic         instr_ready_o;
    logic [W-1:0] decoded_instr_o;
    logic         decoded_instr_valid_o;
    logic         is_ctrl_flow_o;
    logic         decoded_instr_ack_i = 1'b0;
    logic         resolve_branch_i = 1'b0;
    logic [PW:0]  count_o;
    logic         unresolved_branch_o;

    int checks = 0;
    int errors = 0;

    ent_t sb[$];          // entries expected to reach issue, in order
    logic mdl_ctrl[$];    // model of queue contents (control-flow bits)
    logic mdl_flag = 1'b0;

    decoded_instr_queue #(.DEPTH(DEPTH), .ENTRY_W(W)) dut (
        .clk_i                 (clk),
        .rst_ni                (rst_ni),
        .flush_i               (flush_i),
        .instr_i               (instr_i),
        .instr_valid_i         (instr_valid_i),
        .is_ctrl_flow_i        (is_ctrl_flow_i),
        .instr_ready_o         (instr_ready_o),
        .decoded_instr_o       (decoded_instr_o),
        .decoded_instr_valid_o (decoded_instr_valid_o),
        .is_ctrl_flow_o        (is_ctrl_flow_o),
        .decoded_instr_ack_i   (decoded_instr_ack_i),
        .resolve_branch_i      (resolve_branch_i),
        .count_o               (count_o),
        .unresolved_branch_o   (unresolved_branch_o)
    );

    always #5 clk = ~clk;

    function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endfunction

    // Monitor: every DUT hand-off must deliver the oldest expected entry.
    always @(negedge clk) begin
        if (rst_ni && decoded_instr_valid_o && decoded_instr_ack_i) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sb_underflow: got hand-off of %0h expected none (t=%0t)", decoded_instr_o, $time);
            end else begin
                ent_t e;
                e = sb.pop_front();
                chk("out_data", 64'(decoded_instr_o), 64'(e.data));
                chk("out_ctrl", 64'(is_ctrl_flow_o), 64'(e.ctrl));
            end
        end
    end

    // Reference model: predict outputs for the current cycle, then advance.
    always @(negedge clk) begin
        logic exp_ready, exp_valid, exp_isc, head_c, do_pop;
        #1;
        if (!rst_ni) begin
            sb.delete();
            mdl_ctrl.delete();
            mdl_flag = 1'b0;
            chk("rst_ready", 64'(instr_ready_o), 64'd1);
            chk("rst_valid", 64'(decoded_instr_valid_o), 64'd0);
            chk("rst_count", 64'(count_o), 64'd0);
            chk("rst_unres", 64'(unresolved_branch_o), 64'd0);
            chk("rst_isctrl", 64'(is_ctrl_flow_o), 64'd0);
        end else begin
            head_c    = (mdl_ctrl.size() > 0) ? mdl_ctrl[0] : 1'b0;
            exp_ready = (mdl_ctrl.size() < DEPTH) && !flush_i;
            exp_valid = (mdl_ctrl.size() > 0) && !flush_i && !(mdl_flag && head_c);
            exp_isc   = (mdl_ctrl.size() > 0) && head_c;
            chk("ready", 64'(instr_ready_o), 64'(exp_ready));
            chk("valid", 64'(decoded_instr_valid_o), 64'(exp_valid));
            chk("count", 64'(count_o), 64'(mdl_ctrl.size()));
            chk("unres", 64'(unresolved_branch_o), 64'(mdl_flag));
            chk("isctrl", 64'(is_ctrl_flow_o), 64'(exp_isc));
            if (flush_i) begin
                mdl_ctrl.delete();
                sb.delete();
                mdl_flag = 1'b0;
            end else begin
                do_pop = exp_valid && decoded_instr_ack_i;
                if (do_pop) void'(mdl_ctrl.pop_front());
                if (instr_valid_i && exp_ready) begin
                    mdl_ctrl.push_back(is_ctrl_flow_i);
                    sb.push_back('{data: instr_i, ctrl: is_ctrl_flow_i});
                end
                if (do_pop && head_c) mdl_flag = 1'b1;
                else if (resolve_branch_i) mdl_flag = 1'b0;
            end
        end
    end

    // Drive one cycle of inputs shortly after the rising edge.
    task automatic drv(input logic v, input logic c, input logic [W-1:0] d,
                       input logic a, input logic r, input logic f);
        @(posedge clk);
        #1;
        instr_valid_i       = v;
        is_ctrl_flow_i      = c;
        instr_i             = d;
        decoded_instr_ack_i = a;
        resolve_branch_i    = r;
        flush_i             = f;
    endtask

    task automatic idle(input int n, input logic a, input logic r);
        for (int i = 0; i < n; i++) drv(1'b0, 1'b0, '0, a, r, 1'b0);
    endtask

    initial begin
        // Reset held across a falling edge so the reset values are sampled.
        repeat (2) @(posedge clk);
        #1 rst_ni = 1'b1;

        // Fill A..D without ack, attempt a fifth push while full, then drain.
        for (int i = 0; i < 4; i++) drv(1'b1, 1'b0, W'(32'hA0 + i), 1'b0, 1'b0, 1'b0);
        drv(1'b1, 1'b0, W'(32'hEE), 1'b0, 1'b0, 1'b0);
        #2 chk("full_count", 64'(count_o), 64'd4);
        chk("full_ready", 64'(instr_ready_o), 64'd0);
        idle(6, 1'b1, 1'b0);

        // Streaming: one push per cycle with ack held high.
        for (int i = 0; i < 8; i++) drv(1'b1, 1'b0, W'(32'h100 + i), 1'b1, 1'b0, 1'b0);
        idle(2, 1'b1, 1'b0);

        // Branch gate: BR1, ADD, BR2 queued, then ack without resolve.
        drv(1'b1, 1'b1, W'(32'hB1), 1'b0, 1'b0, 1'b0);
        drv(1'b1, 1'b0, W'(32'hADD), 1'b0, 1'b0, 1'b0);
        drv(1'b1, 1'b1, W'(32'hB2), 1'b0, 1'b0, 1'b0);
        idle(8, 1'b1, 1'b0);
        chk("gate_hold_valid", 64'(decoded_instr_valid_o), 64'd0);
        chk("gate_hold_unres", 64'(unresolved_branch_o), 64'd1);
        idle(1, 1'b1, 1'b1);
        idle(2, 1'b1, 1'b0);

        // Resolve/pop collision: blocked ctrl head, resolve clears the flag,
        // then pop it together with a resolve -> flag must stay set.
        drv(1'b1, 1'b1, W'(32'hC1), 1'b1, 1'b0, 1'b0);
        idle(2, 1'b1, 1'b0);
        idle(1, 1'b1, 1'b1);
        idle(1, 1'b1, 1'b1);
        idle(1, 1'b0, 1'b0);
        chk("collision_unres", 64'(unresolved_branch_o), 64'd1);

        // Flush with three entries queued, flag set and a push attempted.
        for (int i = 0; i < 3; i++) drv(1'b1, 1'b0, W'(32'hF0 + i), 1'b0, 1'b0, 1'b0);
        drv(1'b1, 1'b0, W'(32'hDEAD), 1'b0, 1'b0, 1'b1);
        idle(1, 1'b0, 1'b0);
        chk("flush_count", 64'(count_o), 64'd0);
        chk("flush_unres", 64'(unresolved_branch_o), 64'd0);

        // Asynchronous reset with two entries queued.
        for (int i = 0; i < 2; i++) drv(1'b1, 1'b0, W'(32'h200 + i), 1'b0, 1'b0, 1'b0);
        idle(1, 1'b0, 1'b0);
        #2 rst_ni = 1'b0;
        #1;
        chk("arst_count", 64'(count_o), 64'd0);
        chk("arst_valid", 64'(decoded_instr_valid_o), 64'd0);
        chk("arst_ready", 64'(instr_ready_o), 64'd1);
        @(posedge clk);
        #1 rst_ni = 1'b1;
        drv(1'b1, 1'b0, W'(32'h5A5A), 1'b0, 1'b0, 1'b0);
        idle(1, 1'b0, 1'b0);
        #1;
        chk("arst_x_data", 64'(decoded_instr_o), 64'h5A5A);
        chk("arst_x_count", 64'(count_o), 64'd1);
        chk("arst_x_valid", 64'(decoded_instr_valid_o), 64'd1);
        idle(2, 1'b1, 1'b0);

        // Randomized traffic.
        for (int i = 0; i < 500; i++) begin
            drv(($urandom_range(0, 9) < 6), ($urandom_range(0, 9) < 3), W'($urandom),
                ($urandom_range(0, 9) < 6), ($urandom_range(0, 9) < 2),
                ($urandom_range(0, 49) == 0));
        end

        // Drain with resolve held so no entry stays gated.
        idle(12, 1'b1, 1'b1);
        chk("final_count", 64'(count_o), 64'd0);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL sb_leftover: got %0d entries expected 0", sb.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
